// File: rtl/iod_tx_train_pkg.sv
// Shared types and helpers for the IOD TX link-training sequencer.
// The PRBS7 helpers are only used when TX_TRNG_PRBS7_EN is defined.
package iod_tx_train_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StBitTrng  = 3'd1,
        StWordTrng = 3'd2,
        StData     = 3'd3,
        StErr      = 3'd4
    } trng_state_t;

    // x^7 + x^6 + 1: feedback is the XOR of the two MSBs
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    // Advance a PRBS7 register by 'width' bits; each new bit enters at bit 0.
    function automatic logic [6:0] prbs7_step(input logic [6:0] seed, input int unsigned width);
        logic [6:0] s;
        s = seed;
        for (int unsigned i = 0; i < width; i++) begin
            s = {s[5:0], ^(s & PRBS7_TAPS)};
        end
        return s;
    endfunction

endpackage

// File: rtl/iod_tx_prbs7_lane.sv
// Per-lane PRBS7 generator producing DATA_WIDTH bits per cycle, first bit in the LSB.
// Instantiated by iod_tx_train_gen only when TX_TRNG_PRBS7_EN is defined.
module iod_tx_prbs7_lane
    import iod_tx_train_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_IDX   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [6:0] SEED = 7'h7F ^ 7'(LANE_IDX);

    logic [6:0] lfsr_q;
    logic [6:0] step;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= '0;
        end else if (load_i) begin
            lfsr_q <= SEED;
        end else if (advance_i) begin
            lfsr_q <= prbs7_step(lfsr_q, DATA_WIDTH);
        end
    end

    // Bit i is the (i+1)-th generated bit, i.e. bit 0 of the register after i+1 steps.
    always_comb begin
        data_o = '0;
        step   = lfsr_q;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            step      = prbs7_step(lfsr_q, i + 1);
            data_o[i] = step[0];
        end
    end

endmodule

// File: rtl/iod_tx_train_gen.sv
// TX link-training sequencer: bit-align pattern, word-sync pattern, then payload pass-through.
// Define TX_TRNG_PRBS7_EN to send per-lane PRBS7 instead of BIT_PATTERN during bit training.
module iod_tx_train_gen
    import iod_tx_train_pkg::*;
#(
    parameter int unsigned          NUM_LANES    = 4,
    parameter int unsigned          DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] BIT_PATTERN = 8'h55,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 8'hB8,
    parameter int unsigned          MIN_TRNG_CYC = 256,
    parameter int unsigned          TIMEOUT_CYC  = 65535
) (
    input  logic                            SCLK,
    input  logic                            RESET,
    input  logic                            PLL_LOCK,
    input  logic                            TRNG_RSTRT,
    input  logic                            RX_BIT_DONE,
    input  logic                            RX_WORD_DONE,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] TX_DATA_IN,
    input  logic                            TX_DATA_VALID,
    output logic                            TX_DATA_READY,
    output logic [NUM_LANES*DATA_WIDTH-1:0] TX_LANE_DATA,
    output logic                            TRNG_ACTIVE,
    output logic                            TRNG_DONE,
    output logic                            TRNG_ERR,
    output logic [2:0]                      TRNG_STATE
);

    localparam int unsigned         LW     = NUM_LANES * DATA_WIDTH;
    localparam int unsigned         CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]    MIN_M1 = CNT_W'(MIN_TRNG_CYC - 1);
    localparam logic [CNT_W-1:0]    TO_M1  = CNT_W'(TIMEOUT_CYC - 1);

    trng_state_t      state_q, state_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [1:0]       bit_sync_q, word_sync_q;
    logic             bit_done_s, word_done_s;
    logic             restart;
    logic [LW-1:0]    bit_fill;
    logic [LW-1:0]    lane_d;

    assign bit_done_s  = bit_sync_q[1];
    assign word_done_s = word_sync_q[1];
    assign restart     = PLL_LOCK && TRNG_RSTRT;
    assign TRNG_STATE  = state_q;

    always_comb begin
        state_d = state_q;
        if (!PLL_LOCK) begin
            state_d = StIdle;
        end else if (TRNG_RSTRT) begin
            state_d = StBitTrng;
        end else begin
            unique case (state_q)
                StBitTrng: begin
                    if (bit_done_s && phase_cnt_q >= MIN_M1) state_d = StWordTrng;
                    else if (phase_cnt_q == TO_M1)          state_d = StErr;
                end
                StWordTrng: begin
                    if (word_done_s && phase_cnt_q >= MIN_M1) state_d = StData;
                    else if (phase_cnt_q == TO_M1)           state_d = StErr;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A restart re-enters BIT_TRNG even from BIT_TRNG, so it must clear the count as well.
    always_comb begin
        phase_cnt_d = phase_cnt_q;
        if (state_d != state_q || restart) begin
            phase_cnt_d = '0;
        end else if (phase_cnt_q != '1) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
        end
    end

`ifdef TX_TRNG_PRBS7_EN
    logic prbs_load;
    assign prbs_load = (state_d == StBitTrng) && (state_q != StBitTrng || restart);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_prbs
        iod_tx_prbs7_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LANE_IDX   (n)
        ) u_prbs (
            .clk_i     (SCLK),
            .rst_i     (RESET),
            .load_i    (prbs_load),
            .advance_i (state_q == StBitTrng),
            .data_o    (bit_fill[n*DATA_WIDTH +: DATA_WIDTH])
        );
    end
`else
    assign bit_fill = {NUM_LANES{BIT_PATTERN}};
`endif

    always_comb begin
        lane_d = '0;
        unique case (state_q)
            StBitTrng:  lane_d = bit_fill;
            StWordTrng: lane_d = {NUM_LANES{SYNC_WORD}};
            StData:     lane_d = TX_DATA_VALID ? TX_DATA_IN : {NUM_LANES{BIT_PATTERN}};
            default:    lane_d = '0;
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q       <= StIdle;
            phase_cnt_q   <= '0;
            bit_sync_q    <= '0;
            word_sync_q   <= '0;
            TX_LANE_DATA  <= '0;
            TX_DATA_READY <= 1'b0;
            TRNG_ACTIVE   <= 1'b0;
            TRNG_DONE     <= 1'b0;
            TRNG_ERR      <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_cnt_q   <= phase_cnt_d;
            bit_sync_q    <= {bit_sync_q[0], RX_BIT_DONE};
            word_sync_q   <= {word_sync_q[0], RX_WORD_DONE};
            TX_LANE_DATA  <= lane_d;
            // Status decoded from the next state so it lines up with TRNG_STATE.
            TX_DATA_READY <= (state_d == StData);
            TRNG_ACTIVE   <= (state_d == StBitTrng) || (state_d == StWordTrng);
            TRNG_DONE     <= (state_d == StData);
            TRNG_ERR      <= (state_d == StErr);
        end
    end

endmodule
